wb_commit_queue: RTL and testbench
==================================

# wb_commit_queue

Parametrised writeback stage for the 5-stage MIPS pipeline. It buffers up to DEPTH instructions from the memory stage and retires them in order to the register file, one per cycle, under register-file back-pressure. Exceptions, interrupts and ERET are resolved precisely at the queue head. The block gives the decode stage a pending-destination mask and youngest-match forwarding.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- DATA_W, 32: result/PC/BadVAddr width.
- NO_EX, 5'h1f: ex_code value meaning "no exception".
- INT_CODE, 5'h00: ex_code reported for an interrupt.
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ms_to_ws_valid  in  1  memory stage offers an entry.
- ws_allowin  out  1  queue accepts an entry this cycle.
- ms_pc, ms_result, ms_badvaddr  in  DATA_W each  entry PC, ALU/load result, faulting address.
- ms_gr_we  in  1  entry writes a GPR.
- ms_dest  in  5  GPR destination.
- ms_ex_code  in  5  exception code from earlier stages.
- ms_slot, ms_eret  in  1 each  branch-delay-slot flag; ERET flag.
- rf_ready  in  1  register-file write port free this cycle.
- int_pending  in  1  CP0 reports an enabled, unmasked interrupt.
- rf_we  out  1  GPR write strobe.
- rf_waddr  out  5  GPR write address.
- rf_wdata  out  DATA_W  GPR write data.
- debug_wb_pc  out  DATA_W  PC of the retiring entry.
- ex_valid  out  1  one-cycle exception-commit pulse.
- ex_code_o  out  5  exception code.
- ex_pc, ex_badvaddr  out  DATA_W each  EPC and BadVAddr values for CP0.
- ex_slot  out  1  BD bit for CP0.
- eret_valid  out  1  one-cycle ERET-commit pulse.
- flush  out  1  equals ex_valid | eret_valid; kills upstream stages.
- fwd_raddr  in  5  decode-stage source register query.
- fwd_hit  out  1  a valid queued entry writes fwd_raddr (fwd_raddr != 0).
- fwd_data  out  DATA_W  result of the youngest matching entry.
- pend_mask  out  32  bit r set when any valid entry has gr_we and dest==r; bit 0 is always 0.

## Operation
- State: DEPTH entries, head pointer, tail pointer, and an occupancy counter of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: occurs when ms_to_ws_valid && ws_allowin && !flush. The entry is written at tail, tail increments, and count increments.
- ws_allowin = (count < DEPTH) && !flush. There is no same-cycle pass-through when the queue is full.
- Head classification when count > 0. Priority order:
  - int_pending is set: exception, code INT_CODE.
  - Head ex_code != NO_EX: exception, code = head ex_code.
  - Head eret is set: ERET.
  - Otherwise: normal.
- Normal head retires only when rf_ready is high.
  - rf_we = head gr_we, with rf_waddr and rf_wdata taken from the head.
  - Head and count advance by one.
  - When rf_ready is low, nothing changes.
- Exception or ERET head: acts regardless of rf_ready.
  - rf_we = 0.
  - Exception: ex_valid = 1; ex_pc = head pc; ex_badvaddr and ex_slot are taken from the head.
  - ERET: eret_valid = 1.
  - The queue is cleared on the next edge (head = tail = 0, count = 0). Any push in that cycle is discarded.
- Simultaneous push and normal retire: count is unchanged; both pointers advance.
- Forwarding: combinational search over valid entries from tail-1 back to head. The first entry with gr_we && dest == fwd_raddr supplies fwd_data. With no hit, fwd_data = 0.
- Entries carrying an exception still contribute to pend_mask and forwarding until flushed. Decode is flushed in the same cycle, so this is harmless.

## Timing
- Reset (resetn low, asynchronous): count = 0, pointers = 0, entry valid state cleared.
- Outputs during reset:
  - ws_allowin = 1.
  - rf_we, ex_valid, eret_valid, flush, fwd_hit = 0.
  - pend_mask = 0, and every data output = 0.
- Latency: an entry pushed at edge N is at the head from N and can retire in cycle N+1 at the earliest, if the queue was empty.
- Throughput: one retire per cycle while rf_ready is high.
- rf_we, ex_valid and eret_valid depend combinationally on head state, rf_ready and int_pending. They are not registered.
- int_pending with an empty queue: no action. The interrupt is taken on the next valid head.
- A reset asserted mid-flush or mid-retire overrides everything. No partial write persists.
- Count never exceeds DEPTH and never goes below 0.
- Full and empty are derived from count, not from pointer equality.

## Test plan
- Fill, then drain:
  - Stimulus: rf_ready=0; push 4 entries with dest 1..4 and results 0x11..0x44.
  - ws_allowin drops after the 4th push; pend_mask = 0x1E.
  - Raise rf_ready: rf_we on 4 consecutive cycles, with waddr 1,2,3,4 in order, then ws_allowin = 1.
- Forwarding priority:
  - Stimulus: queue entries dest 5 = 0xA, then dest 5 = 0xB; query fwd_raddr = 5.
  - Required: fwd_hit = 1, fwd_data = 0xB.
  - Query fwd_raddr = 0: fwd_hit = 0.
- Precise exception:
  - Stimulus: entries normal, ex_code 5'h04 (pc 0xBFC00100, badvaddr 0x3), normal; rf_ready = 1.
  - Required: 1st entry retires; next cycle ex_valid = 1, ex_code_o = 4, ex_pc = 0xBFC00100, ex_badvaddr = 3, rf_we = 0.
  - Then count = 0; the 3rd entry never writes.
- Interrupt:
  - Stimulus: int_pending = 1 with a normal head, rf_ready = 0.
  - Required: ex_valid = 1, ex_code_o = 0, flush = 1, no GPR write.
- ERET:
  - Stimulus: head eret = 1, with a concurrent ms_to_ws_valid.
  - Required: eret_valid = 1, push discarded, queue empty next cycle.
- Async reset:
  - Stimulus: drop resetn mid-cycle with 3 entries queued.
  - Required: all outputs go to reset values immediately; after release, ws_allowin = 1 and pend_mask = 0.

Source files
------------

// File: rtl/wb_commit_queue.sv
// In-order writeback queue: buffers memory-stage results and retires them to the GPR file,
// resolving exceptions, interrupts and ERET precisely at the head.
module wb_commit_queue #(
    parameter int         DEPTH    = 4,
    parameter int         DATA_W   = 32,
    parameter logic [4:0] NO_EX    = 5'h1f,
    parameter logic [4:0] INT_CODE = 5'h00
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [DATA_W-1:0] ms_pc,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [DATA_W-1:0] ms_badvaddr,
    input  logic              ms_gr_we,
    input  logic [4:0]        ms_dest,
    input  logic [4:0]        ms_ex_code,
    input  logic              ms_slot,
    input  logic              ms_eret,
    input  logic              rf_ready,
    input  logic              int_pending,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic              ex_valid,
    output logic [4:0]        ex_code_o,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_badvaddr,
    output logic              ex_slot,
    output logic              eret_valid,
    output logic              flush,
    input  logic [4:0]        fwd_raddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       pend_mask
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] res_q  [DEPTH];
    logic [DATA_W-1:0] bva_q  [DEPTH];
    logic [4:0]        dest_q [DEPTH];
    logic [4:0]        exc_q  [DEPTH];
    logic [DEPTH-1:0]  we_q, slot_q, eret_q, valid_q;

    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic has_head, take_ex, take_eret, retire, push;

    assign has_head  = (count_q != '0);
    assign take_ex   = has_head && (int_pending || (exc_q[head_q] != NO_EX));
    assign take_eret = has_head && !take_ex && eret_q[head_q];
    assign retire    = has_head && !take_ex && !take_eret && rf_ready;

    assign ex_valid   = take_ex;
    assign eret_valid = take_eret;
    assign flush      = take_ex | take_eret;
    assign ws_allowin = (count_q < FULL) && !flush;
    assign push       = ms_to_ws_valid && ws_allowin;

    // Data outputs are zeroed unless their strobe is active so reset/idle shows all-zero.
    assign rf_we       = retire && we_q[head_q];
    assign rf_waddr    = rf_we ? dest_q[head_q] : 5'd0;
    assign rf_wdata    = rf_we ? res_q[head_q] : '0;
    assign debug_wb_pc = retire ? pc_q[head_q] : '0;
    assign ex_code_o   = !take_ex ? 5'd0 : (int_pending ? INT_CODE : exc_q[head_q]);
    assign ex_pc       = take_ex ? pc_q[head_q] : '0;
    assign ex_badvaddr = take_ex ? bva_q[head_q] : '0;
    assign ex_slot     = take_ex && slot_q[head_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push && !retire)
                count_q <= count_q + 1'b1;
            else if (!push && retire)
                count_q <= count_q - 1'b1;
        end
    end

    // Payload needs no reset: every consumer is qualified by valid_q or count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]   <= ms_pc;
            res_q[tail_q]  <= ms_result;
            bva_q[tail_q]  <= ms_badvaddr;
            dest_q[tail_q] <= ms_dest;
            exc_q[tail_q]  <= ms_ex_code;
            we_q[tail_q]   <= ms_gr_we;
            slot_q[tail_q] <= ms_slot;
            eret_q[tail_q] <= ms_eret;
        end
    end

    // Walk oldest to youngest so the youngest match is the one left standing.
    logic [AW-1:0] idx;
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (valid_q[idx] && we_q[idx] && (dest_q[idx] == fwd_raddr) && (fwd_raddr != 5'd0)) begin
                fwd_hit  = 1'b1;
                fwd_data = res_q[idx];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && we_q[i])
                pend_mask[dest_q[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: fill/drain, forwarding, exceptions, interrupt, ERET, async reset.
module tb_wb_commit_queue;

    logic        clk, resetn;
    logic        ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc, ms_result, ms_badvaddr;
    logic        ms_gr_we, ms_slot, ms_eret;
    logic [4:0]  ms_dest, ms_ex_code;
    logic        rf_ready, int_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc;
    logic        ex_valid, ex_slot, eret_valid, flush;
    logic [4:0]  ex_code_o;
    logic [31:0] ex_pc, ex_badvaddr;
    logic [4:0]  fwd_raddr;
    logic        fwd_hit;
    logic [31:0] fwd_data, pend_mask;

    int n_cmp = 0;
    int n_err = 0;

    wb_commit_queue dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_badvaddr(ms_badvaddr),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_ex_code(ms_ex_code),
        .ms_slot(ms_slot), .ms_eret(ms_eret),
        .rf_ready(rf_ready), .int_pending(int_pending),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
        .ex_valid(ex_valid), .ex_code_o(ex_code_o), .ex_pc(ex_pc), .ex_badvaddr(ex_badvaddr),
        .ex_slot(ex_slot), .eret_valid(eret_valid), .flush(flush),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_entry(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                             input logic [4:0] exc, input logic eret, input logic we);
        ms_pc = pc; ms_dest = dest; ms_result = res; ms_ex_code = exc;
        ms_eret = eret; ms_gr_we = we; ms_badvaddr = 32'h0; ms_slot = 1'b0;
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                              input logic [4:0] exc, input logic eret, input logic we);
        @(negedge clk);
        set_entry(pc, dest, res, exc, eret, we);
        ms_to_ws_valid = 1'b1;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #2;
        n_cmp++; if (ws_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin got %b want 1", ws_allowin); end
        n_cmp++; if ({rf_we, ex_valid, eret_valid, flush, fwd_hit} !== 5'b0) begin n_err++;
            $display("FAIL reset_strobes got %b want 00000", {rf_we, ex_valid, eret_valid, flush, fwd_hit}); end
        n_cmp++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL reset_pend got %h want 0", pend_mask); end
        n_cmp++; if ({rf_wdata, debug_wb_pc, ex_pc, fwd_data} !== 128'h0) begin n_err++;
            $display("FAIL reset_data got %h %h %h %h want 0", rf_wdata, debug_wb_pc, ex_pc, fwd_data); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_fill_drain;
        rf_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push_entry(32'h1000 + 32'(k * 4), 5'(k), 32'(k * 'h11), 5'h1f, 1'b0, 1'b1);
            if (k == 3) begin
                n_cmp++; if (ws_allowin !== 1'b1) begin n_err++; $display("FAIL fill_allow3 got %b want 1", ws_allowin); end
            end
        end
        n_cmp++; if (ws_allowin !== 1'b0) begin n_err++; $display("FAIL fill_full_allow got %b want 0", ws_allowin); end
        n_cmp++; if (pend_mask !== 32'h1E) begin n_err++; $display("FAIL fill_pend got %h want 1e", pend_mask); end
        // offered while full: must be dropped
        push_entry(32'h2000, 5'd6, 32'h66, 5'h1f, 1'b0, 1'b1);
        @(negedge clk);
        rf_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(k), 32'(k * 'h11)}) begin n_err++;
                $display("FAIL drain_%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", k, rf_we, rf_waddr, rf_wdata, k, k * 'h11); end
            n_cmp++; if (debug_wb_pc !== 32'h1000 + 32'(k * 4)) begin n_err++;
                $display("FAIL drain_pc_%0d got %h want %h", k, debug_wb_pc, 32'h1000 + k * 4); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL drain_empty_we got %b want 0", rf_we); end
        n_cmp++; if (ws_allowin !== 1'b1) begin n_err++; $display("FAIL drain_allow got %b want 1", ws_allowin); end
        n_cmp++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL drain_pend got %h want 0", pend_mask); end
        rf_ready = 1'b0;
    endtask

    task automatic test_forwarding;
        rf_ready = 1'b0;
        push_entry(32'h10, 5'd5, 32'hA, 5'h1f, 1'b0, 1'b1);
        push_entry(32'h14, 5'd5, 32'hB, 5'h1f, 1'b0, 1'b1);
        push_entry(32'h18, 5'd7, 32'hC, 5'h1f, 1'b0, 1'b1);
        fwd_raddr = 5'd5; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'hB}) begin n_err++;
            $display("FAIL fwd_young got hit=%b d=%h want hit=1 d=b", fwd_hit, fwd_data); end
        fwd_raddr = 5'd7; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'hC}) begin n_err++;
            $display("FAIL fwd_r7 got hit=%b d=%h want hit=1 d=c", fwd_hit, fwd_data); end
        fwd_raddr = 5'd0; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) begin n_err++;
            $display("FAIL fwd_r0 got hit=%b d=%h want hit=0 d=0", fwd_hit, fwd_data); end
        fwd_raddr = 5'd9; #1;
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_miss got %b want 0", fwd_hit); end
        n_cmp++; if (pend_mask !== 32'hA0) begin n_err++; $display("FAIL fwd_pend got %h want a0", pend_mask); end
        @(negedge clk); rf_ready = 1'b1;
        @(posedge clk); #1;
        fwd_raddr = 5'd5; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'hB}) begin n_err++;
            $display("FAIL fwd_after_retire got hit=%b d=%h want hit=1 d=b", fwd_hit, fwd_data); end
        repeat (2) @(posedge clk);
        @(negedge clk); rf_ready = 1'b0; fwd_raddr = 5'd0;
        n_cmp++; if (ws_allowin !== 1'b1 || pend_mask !== 32'h0) begin n_err++;
            $display("FAIL fwd_drained got allow=%b pend=%h want 1 0", ws_allowin, pend_mask); end
    endtask

    task automatic test_exception;
        @(negedge clk);
        rf_ready = 1'b1;
        set_entry(32'h100, 5'd8, 32'h88, 5'h1f, 1'b0, 1'b1);
        ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata, debug_wb_pc} !== {1'b1, 5'd8, 32'h88, 32'h100}) begin n_err++;
            $display("FAIL exc_first got we=%b a=%0d d=%h pc=%h want 1 8 88 100", rf_we, rf_waddr, rf_wdata, debug_wb_pc); end
        @(negedge clk);
        set_entry(32'hBFC00100, 5'd9, 32'h99, 5'h04, 1'b0, 1'b1);
        ms_badvaddr = 32'h3; ms_slot = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({ex_valid, ex_code_o, ex_pc, ex_badvaddr, ex_slot} !== {1'b1, 5'd4, 32'hBFC00100, 32'h3, 1'b1}) begin n_err++;
            $display("FAIL exc_head got v=%b c=%h pc=%h bva=%h bd=%b want 1 04 bfc00100 3 1", ex_valid, ex_code_o, ex_pc, ex_badvaddr, ex_slot); end
        n_cmp++; if ({rf_we, flush, ws_allowin, eret_valid} !== 4'b0100) begin n_err++;
            $display("FAIL exc_ctl got we=%b fl=%b al=%b er=%b want 0 1 0 0", rf_we, flush, ws_allowin, eret_valid); end
        n_cmp++; if (pend_mask !== 32'h200) begin n_err++; $display("FAIL exc_pend got %h want 200", pend_mask); end
        @(negedge clk);
        set_entry(32'h108, 5'd10, 32'hAA, 5'h1f, 1'b0, 1'b1);
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        n_cmp++; if ({rf_we, ex_valid, ws_allowin} !== 3'b001 || pend_mask !== 32'h0) begin n_err++;
            $display("FAIL exc_cleared got we=%b ex=%b al=%b pend=%h want 0 0 1 0", rf_we, ex_valid, ws_allowin, pend_mask); end
        @(posedge clk); #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL exc_third_write got %b want 0", rf_we); end
        rf_ready = 1'b0;
    endtask

    task automatic test_interrupt;
        rf_ready = 1'b0;
        int_pending = 1'b1;
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL int_empty got %b want 0", ex_valid); end
        int_pending = 1'b0;
        push_entry(32'h200, 5'd3, 32'h33, 5'h1f, 1'b0, 1'b1);
        n_cmp++; if (ex_valid !== 1'b0 || rf_we !== 1'b0) begin n_err++;
            $display("FAIL int_idle got ex=%b we=%b want 0 0", ex_valid, rf_we); end
        @(negedge clk);
        int_pending = 1'b1; #1;
        n_cmp++; if ({ex_valid, ex_code_o, flush, rf_we, ex_pc} !== {1'b1, 5'd0, 1'b1, 1'b0, 32'h200}) begin n_err++;
            $display("FAIL int_take got ex=%b c=%h fl=%b we=%b pc=%h want 1 00 1 0 200", ex_valid, ex_code_o, flush, rf_we, ex_pc); end
        @(posedge clk); #1;
        n_cmp++; if ({ex_valid, ws_allowin, rf_we} !== 3'b010) begin n_err++;
            $display("FAIL int_after got ex=%b al=%b we=%b want 0 1 0", ex_valid, ws_allowin, rf_we); end
        int_pending = 1'b0;
    endtask

    task automatic test_eret;
        rf_ready = 1'b0;
        push_entry(32'h300, 5'd0, 32'h0, 5'h1f, 1'b1, 1'b0);
        @(negedge clk);
        set_entry(32'h304, 5'd4, 32'h44, 5'h1f, 1'b0, 1'b1);
        ms_to_ws_valid = 1'b1; #1;
        n_cmp++; if ({eret_valid, flush, ex_valid, ws_allowin, rf_we} !== 5'b11000) begin n_err++;
            $display("FAIL eret_head got er=%b fl=%b ex=%b al=%b we=%b want 1 1 0 0 0", eret_valid, flush, ex_valid, ws_allowin, rf_we); end
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        rf_ready = 1'b1; #1;
        n_cmp++; if ({eret_valid, rf_we, ws_allowin} !== 3'b001 || pend_mask !== 32'h0) begin n_err++;
            $display("FAIL eret_after got er=%b we=%b al=%b pend=%h want 0 0 1 0", eret_valid, rf_we, ws_allowin, pend_mask); end
        rf_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        rf_ready = 1'b0;
        push_entry(32'h400, 5'd1, 32'h1, 5'h1f, 1'b0, 1'b1);
        push_entry(32'h404, 5'd2, 32'h2, 5'h1f, 1'b0, 1'b1);
        push_entry(32'h408, 5'd3, 32'h3, 5'h1f, 1'b0, 1'b1);
        n_cmp++; if (pend_mask !== 32'hE) begin n_err++; $display("FAIL ar_pend_pre got %h want e", pend_mask); end
        @(negedge clk); #2;
        fwd_raddr = 5'd2; rf_ready = 1'b1; int_pending = 1'b1;
        resetn = 1'b0; #1;
        n_cmp++; if ({ws_allowin, rf_we, ex_valid, flush, fwd_hit} !== 5'b10000) begin n_err++;
            $display("FAIL ar_strobes got al=%b we=%b ex=%b fl=%b hit=%b want 1 0 0 0 0", ws_allowin, rf_we, ex_valid, flush, fwd_hit); end
        n_cmp++; if ({pend_mask, fwd_data, ex_pc, rf_wdata} !== 128'h0) begin n_err++;
            $display("FAIL ar_data got pend=%h fd=%h epc=%h wd=%h want 0", pend_mask, fwd_data, ex_pc, rf_wdata); end
        @(negedge clk);
        int_pending = 1'b0;
        resetn = 1'b1; #1;
        n_cmp++; if ({ws_allowin, rf_we} !== 2'b10 || pend_mask !== 32'h0) begin n_err++;
            $display("FAIL ar_release got al=%b we=%b pend=%h want 1 0 0", ws_allowin, rf_we, pend_mask); end
        rf_ready = 1'b0; fwd_raddr = 5'd0;
    endtask

    initial begin
        ms_to_ws_valid = 1'b0; rf_ready = 1'b0; int_pending = 1'b0; fwd_raddr = 5'd0;
        set_entry(32'h0, 5'd0, 32'h0, 5'h1f, 1'b0, 1'b0);
        test_reset();
        test_fill_drain();
        test_forwarding();
        test_exception();
        test_interrupt();
        test_eret();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
